// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed program store answering fetch requests
// after a fixed number of wait states, with a streaming program-load port.
module imem_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic        imem_ready,
    output logic [31:0] imem_rdata,
    output logic        imem_valid,
    output logic        imem_oob,
    input  logic        load_en,
    input  logic        load_wvalid,
    input  logic [31:0] load_wdata,
    output logic        load_ready,
    output logic        load_done
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]            WAIT_CNT = 4'(WAIT_STATES);
    localparam logic [DEPTH_LOG2-1:0] PTR_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  valid_q, valid_d;
    logic                  oob_q, oob_d;
    logic                  done_q, done_d;

    logic                  resp_en;
    logic [31:0]           resp_addr;
    logic                  mem_we;

    logic [31:0]           mem [DEPTH];

    function automatic logic addr_in_range(input logic [31:0] a);
        return (a >> DEPTH_LOG2) == 32'd0;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        done_d     = 1'b0;
        resp_en    = 1'b0;
        resp_addr  = addr_q;
        mem_we     = 1'b0;
        imem_ready = 1'b0;
        load_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                imem_ready = 1'b1;
                if (load_en) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                end else if (imem_req) begin
                    if (WAIT_STATES == 0) begin
                        resp_en   = 1'b1;
                        resp_addr = imem_addr;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_CNT;
                        addr_d  = imem_addr;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    resp_en = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                if (load_wvalid) begin
                    // Writes are suppressed while reset is asserted so an aborted load leaves no stray word.
                    mem_we = rst_n;
                    ptr_d  = ptr_q + 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                if (!load_en) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        valid_d = resp_en;
        oob_d   = resp_en && !addr_in_range(resp_addr);
        rdata_d = rdata_q;
        if (resp_en) begin
            rdata_d = addr_in_range(resp_addr) ? mem[resp_addr[DEPTH_LOG2-1:0]] : NOP_WORD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            rdata_q <= NOP_WORD;
            valid_q <= 1'b0;
            oob_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            oob_q   <= oob_d;
            done_q  <= done_d;
        end
    end

    // Captured fetch address and array contents carry no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        if (mem_we) begin
            mem[ptr_q] <= load_wdata;
        end
    end

    assign imem_rdata = rdata_q;
    assign imem_valid = valid_q;
    assign imem_oob   = oob_q;
    assign load_done  = done_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a zero-wait and a three-wait instance share stimulus and are
// compared every cycle against a transaction-level model of the responder.
module tb_imem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        load_en;
    logic        load_wvalid;
    logic [31:0] load_wdata;

    logic        rdy    [2];
    logic [31:0] rdata  [2];
    logic        valid  [2];
    logic        oob    [2];
    logic        ld_rdy [2];
    logic        done   [2];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0), .NOP_WORD(NOP)) u_w0 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(rdy[0]),
        .imem_rdata(rdata[0]), .imem_valid(valid[0]), .imem_oob(oob[0]),
        .load_en(load_en), .load_wvalid(load_wvalid), .load_wdata(load_wdata),
        .load_ready(ld_rdy[0]), .load_done(done[0])
    );

    imem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(3), .NOP_WORD(NOP)) u_w3 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(rdy[1]),
        .imem_rdata(rdata[1]), .imem_valid(valid[1]), .imem_oob(oob[1]),
        .load_en(load_en), .load_wvalid(load_wvalid), .load_wdata(load_wdata),
        .load_ready(ld_rdy[1]), .load_done(done[1])
    );

    // Reference model: per instance, program contents plus "busy for N more cycles" / "loading" status.
    logic [31:0] m_mem  [2][DEPTH];
    bit          m_ld   [2];
    int          m_ptr  [2];
    int          m_busy [2];
    logic [31:0] m_pend [2];
    logic        e_valid[2];
    logic        e_oob  [2];
    logic        e_done [2];
    logic [31:0] e_rdata[2];

    function automatic int wait_of(int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic respond(int k, logic [31:0] a);
        e_valid[k] = 1'b1;
        if (a >= DEPTH) begin
            e_rdata[k] = NOP;
            e_oob[k]   = 1'b1;
        end else begin
            e_rdata[k] = m_mem[k][a[9:0]];
        end
    endtask

    task automatic model_edge(int k);
        e_valid[k] = 1'b0;
        e_oob[k]   = 1'b0;
        e_done[k]  = 1'b0;
        if (!rst_n) begin
            m_ld[k]    = 1'b0;
            m_ptr[k]   = 0;
            m_busy[k]  = 0;
            e_rdata[k] = NOP;
        end else if (m_ld[k]) begin
            if (load_wvalid) begin
                m_mem[k][m_ptr[k]] = load_wdata;
                if (m_ptr[k] == DEPTH - 1) begin
                    m_ptr[k]  = 0;
                    m_ld[k]   = 1'b0;
                    e_done[k] = 1'b1;
                end else begin
                    m_ptr[k]++;
                end
            end
            if (m_ld[k] && !load_en) begin
                m_ld[k]   = 1'b0;
                e_done[k] = 1'b1;
            end
        end else if (m_busy[k] > 0) begin
            m_busy[k]--;
            if (m_busy[k] == 0) respond(k, m_pend[k]);
        end else if (load_en) begin
            m_ld[k]  = 1'b1;
            m_ptr[k] = 0;
        end else if (imem_req) begin
            if (wait_of(k) == 0) begin
                respond(k, imem_addr);
            end else begin
                m_busy[k] = wait_of(k);
                m_pend[k] = imem_addr;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("valid[w%0d]", wait_of(k)), 32'(valid[k]), 32'(e_valid[k]));
            chk($sformatf("oob[w%0d]", wait_of(k)), 32'(oob[k]), 32'(e_oob[k]));
            chk($sformatf("rdata[w%0d]", wait_of(k)), rdata[k], e_rdata[k]);
            chk($sformatf("load_done[w%0d]", wait_of(k)), 32'(done[k]), 32'(e_done[k]));
            chk($sformatf("imem_ready[w%0d]", wait_of(k)), 32'(rdy[k]),
                32'(!m_ld[k] && m_busy[k] == 0));
            chk($sformatf("load_ready[w%0d]", wait_of(k)), 32'(ld_rdy[k]), 32'(m_ld[k]));
        end
    endtask

    task automatic idle(int n);
        imem_req    = 1'b0;
        load_en     = 1'b0;
        load_wvalid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic read(logic [31:0] a);
        imem_req  = 1'b1;
        imem_addr = a;
        tick();
    endtask

    task automatic load_words(int n, bit random_gaps);
        int written;
        imem_req = 1'b0;
        load_en  = 1'b1;
        tick();
        written = 0;
        while (written < n) begin
            load_wvalid = random_gaps ? 1'(($urandom_range(0, 3) != 0)) : 1'b1;
            load_wdata  = $urandom;
            tick();
            if (load_wvalid) written++;
        end
        load_wvalid = 1'b0;
        load_en     = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h0050_0093; prog[1] = 32'h00a0_0113;
        prog[2] = 32'h0020_81b3; prog[3] = 32'h0000_006f;
        for (int k = 0; k < 2; k++) begin
            m_ld[k] = 1'b0; m_ptr[k] = 0; m_busy[k] = 0; m_pend[k] = '0;
            e_rdata[k] = NOP;
        end
        rst_n = 1'b0; imem_req = 1'b0; imem_addr = '0;
        load_en = 1'b0; load_wvalid = 1'b0; load_wdata = '0;

        // Reset state
        tick(); tick();
        rst_n = 1'b1;
        idle(2);

        // Load a short program, then back-to-back reads of it
        load_en = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            load_wvalid = 1'b1;
            load_wdata  = prog[i];
            tick();
        end
        idle(2);
        for (int i = 0; i < 4; i++) read(32'(i));
        idle(5);

        // Address changes during the wait window are ignored
        read(32'd2);
        imem_req  = 1'b0;
        imem_addr = 32'd0;
        for (int i = 0; i < 5; i++) tick();

        // Out-of-range reads, first just past the array
        read(32'h0000_0400);
        idle(5);
        read(32'hffff_fffc);
        idle(5);

        // Load wins over a simultaneous fetch request; early exit after two words
        imem_req  = 1'b1;
        imem_addr = 32'd3;
        load_en   = 1'b1;
        tick();
        imem_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_wvalid = 1'b1;
            load_wdata  = $urandom;
            tick();
        end
        load_wvalid = 1'b0;
        load_en     = 1'b0;
        tick();
        idle(1);
        read(32'd0);
        idle(4);
        read(32'd1);
        idle(5);

        // Full-array load with load_en held through the last word
        load_en = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            load_wvalid = 1'b1;
            load_wdata  = $urandom;
            tick();
        end
        idle(3);
        read(32'd0);
        idle(4);
        read(32'(DEPTH - 1));
        idle(5);

        // Randomized reads interleaved with randomized short loads
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 120; i++) begin
                imem_req  = 1'(($urandom_range(0, 3) != 0));
                imem_addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
                tick();
            end
            idle(5);
            load_words($urandom_range(3, 20), 1'b1);
            idle(2);
            for (int i = 0; i < 8; i++) read(32'(i));
            idle(5);
        end

        // Reset during a wait window aborts the pending response
        read(32'd7);
        imem_req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(5);

        // Reset during a load: no done pulse, words already written survive
        load_en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            load_wvalid = 1'b1;
            load_wdata  = $urandom;
            tick();
        end
        load_wvalid = 1'b0;
        load_en     = 1'b0;
        rst_n       = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(3);
        for (int i = 0; i < 3; i++) read(32'(i));
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
